// File: rtl/imm_dispatch_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | imm_dispatch_ctrl_pkg                                                    |
// | Shared widths, immediate type codes and opcodes for imm_dispatch_ctrl.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package imm_dispatch_ctrl_pkg;

   localparam int INST_BUS = 16;
   localparam int DATA_BUS = 16;

   typedef enum logic [2:0] {
      IMM_NONE  = 3'd0,
      IMM_ZE8   = 3'd1,
      IMM_SE11  = 3'd2,
      IMM_SE8   = 3'd3,
      IMM_SE5   = 3'd4,
      IMM_SE4   = 3'd5,
      IMM_SHAMT = 3'd6
   } imm_type_t;

   localparam logic [4:0] c_op_b      = 5'b00010;
   localparam logic [4:0] c_op_beqz   = 5'b00100;
   localparam logic [4:0] c_op_bnez   = 5'b00101;
   localparam logic [4:0] c_op_shift  = 5'b00110;
   localparam logic [4:0] c_op_addiu3 = 5'b01000;
   localparam logic [4:0] c_op_addiu  = 5'b01001;
   localparam logic [4:0] c_op_slti   = 5'b01010;
   localparam logic [4:0] c_op_misc   = 5'b01100;
   localparam logic [4:0] c_op_li     = 5'b01101;
   localparam logic [4:0] c_op_cmpi   = 5'b01110;
   localparam logic [4:0] c_op_lw_sp  = 5'b10010;
   localparam logic [4:0] c_op_lw     = 5'b10011;
   localparam logic [4:0] c_op_sw_sp  = 5'b11010;
   localparam logic [4:0] c_op_sw     = 5'b11011;

   localparam logic [2:0] c_sub_bteqz = 3'b000;
   localparam logic [2:0] c_sub_btnez = 3'b001;
   localparam logic [2:0] c_sub_addsp = 3'b011;

   typedef struct packed {
      logic [INST_BUS-1:0] inst;
      logic [DATA_BUS-1:0] imm;
      imm_type_t           imm_type;
      logic                illegal;
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_dispatch_ctrl_imm_classify.sv
// +--------------------------------------------------------------------------+
// | imm_dispatch_ctrl_imm_classify                                           |
// | Combinational opcode classifier and immediate extender.                  |
// | Optional: IMM_DISPATCH_TRAP_EN flags opcodes outside the ISA list.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_dispatch_ctrl_imm_classify
   import imm_dispatch_ctrl_pkg::*;
(
   input  logic [INST_BUS-1:0] inst,
   output imm_type_t           imm_type,
   output logic [DATA_BUS-1:0] imm,
   output logic                illegal
);

   logic [4:0] w_op;
   logic [2:0] w_sub;
   logic [2:0] w_shamt;

   assign w_op    = inst[15:11];
   assign w_sub   = inst[10:8];
   assign w_shamt = inst[4:2];

   always_comb begin
      imm_type = IMM_NONE;
      case (w_op)
         c_op_b:                             imm_type = IMM_SE11;
         c_op_addiu, c_op_beqz, c_op_bnez,
         c_op_cmpi, c_op_slti, c_op_lw_sp,
         c_op_sw_sp:                         imm_type = IMM_SE8;
         c_op_misc: begin
            if (w_sub == c_sub_bteqz || w_sub == c_sub_btnez || w_sub == c_sub_addsp)
               imm_type = IMM_SE8;
         end
         c_op_li:                            imm_type = IMM_ZE8;
         c_op_lw, c_op_sw:                   imm_type = IMM_SE5;
         c_op_addiu3:                        imm_type = IMM_SE4;
         c_op_shift:                         imm_type = IMM_SHAMT;
         default:                            imm_type = IMM_NONE;
      endcase
   end

   always_comb begin
      imm = '0;
      case (imm_type)
         IMM_ZE8:   imm = {8'h00, inst[7:0]};
         IMM_SE11:  imm = {{5{inst[10]}}, inst[10:0]};
         IMM_SE8:   imm = {{8{inst[7]}}, inst[7:0]};
         IMM_SE5:   imm = {{11{inst[4]}}, inst[4:0]};
         IMM_SE4:   imm = {{12{inst[3]}}, inst[3:0]};
         // A zero shift field encodes a shift by eight.
         IMM_SHAMT: imm = (w_shamt == 3'd0) ? 16'd8 : {13'd0, w_shamt};
         default:   imm = '0;
      endcase
   end

`ifdef IMM_DISPATCH_TRAP_EN
   always_comb begin
      case (w_op)
         c_op_b, c_op_beqz, c_op_bnez, c_op_shift, c_op_addiu3, c_op_addiu,
         c_op_slti, c_op_misc, c_op_li, c_op_cmpi, c_op_lw_sp, c_op_lw,
         c_op_sw_sp, c_op_sw: illegal = 1'b0;
         default:             illegal = 1'b1;
      endcase
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/imm_dispatch_ctrl.sv
// +--------------------------------------------------------------------------+
// | imm_dispatch_ctrl                                                        |
// | Decode-stage immediate controller with a 2-entry skid buffer toward EX.  |
// | Optional: IMM_DISPATCH_TRAP_EN enables out_illegal reporting.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module imm_dispatch_ctrl
   import imm_dispatch_ctrl_pkg::*;
#(
   parameter int INST_W = INST_BUS,
   parameter int DATA_W = DATA_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [INST_W-1:0] in_inst,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [DATA_W-1:0] out_imm,
   output logic [2:0]        out_imm_type,
   output logic              out_illegal
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t r_state;
   logic   r_in_ready;
   logic   r_out_valid;
   entry_t r_head;
   entry_t r_skid;
   entry_t w_new;
   logic   w_accept;
   logic   w_pop;

   imm_dispatch_ctrl_imm_classify u_imm_classify (
      .inst     (in_inst),
      .imm_type (w_new.imm_type),
      .imm      (w_new.imm),
      .illegal  (w_new.illegal)
   );
   assign w_new.inst = in_inst;

   assign w_accept = in_valid & r_in_ready;
   assign w_pop    = r_out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_head      <= '0;
         r_skid      <= '0;
      end else if (flush) begin
         r_state     <= ST_EMPTY;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_head      <= w_new;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (w_accept && w_pop) begin
                  r_head <= w_new;
               end else if (w_accept) begin
                  r_skid     <= w_new;
                  r_in_ready <= 1'b0;
                  r_state    <= ST_TWO;
               end else if (w_pop) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_EMPTY;
               end
            end
            // in_ready is low here, so only a pop can move the buffer.
            ST_TWO: begin
               if (w_pop) begin
                  r_head     <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= ST_ONE;
               end
            end
            default: begin
               r_state     <= ST_EMPTY;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_inst     = r_head.inst;
   assign out_imm      = r_head.imm;
   assign out_imm_type = r_head.imm_type;
   assign out_illegal  = r_head.illegal;

endmodule

`default_nettype wire
